// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   arb_state_t : state encoding of the uart_tx_arbiter sequencer
//   BYTE_W      : width of one serial byte
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at last_gnt+1, wrapping modulo N_REQ, and returns the
// first set bit.
//   req      in  N_REQ  request vector
//   last_gnt in  IDX_W  index of the most recent completed grant
//   gnt      out N_REQ  one-hot winner (all zeros when no request)
//   gnt_idx  out IDX_W  index of the winner (0 when no request)
//   found    out 1      at least one request is set
module uart_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    // Offsets 1..N_REQ: the previous owner is visited last, so it can only
    // win again when nobody else is asking.
    for (int k = 1; k <= N_REQ; k++) begin
      pos = IDX_W'((int'(last_gnt) + k) % N_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        gnt[pos]   = 1'b1;
        gnt_idx    = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte producers.
// A round-robin pick launches one byte at a time through the
// uart_tx_en/uart_tx_data/uart_tx_busy interface, then waits for the
// serializer to accept (busy rises) and to finish (busy falls).
// Optional feature macro: UART_TX_ARB_LOCK_EN -- adds req_last and keeps the
// arbiter locked to one requester until the last byte of its message is sent.
//   clk          in  1         system clock
//   resetn       in  1         asynchronous active-low reset
//   req_valid    in  N_REQ     requester i has a byte
//   req_data     in  8*N_REQ   byte of requester i at [8i+7:8i]
//   req_ready    out N_REQ     byte of requester i accepted this cycle
//   req_last     in  N_REQ     final byte of a message (lock build only)
//   uart_tx_en   out 1         launch request to uart_tx
//   uart_tx_data out 8         byte to uart_tx, stable while uart_tx_en high
//   uart_tx_busy in  1         serializer is transmitting
//   arb_gnt      out N_REQ     one-hot owner of the byte in flight
//   arb_err      out 1         one-cycle pulse on launch timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_last,
`endif
  output logic                    uart_tx_en,
  output logic [BYTE_W-1:0]       uart_tx_data,
  input  logic                    uart_tx_busy,
  output logic [N_REQ-1:0]        arb_gnt,
  output logic                    arb_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  arb_state_t       state, state_nx;
  logic [IDX_W-1:0] last_gnt, last_nx;
  logic [IDX_W-1:0] cur_idx, cur_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             en_nx;
  logic [BYTE_W-1:0] data_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic             err_nx;

  logic [N_REQ-1:0] req_elig;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             launch;
  logic             timeout;
  logic [BYTE_W-1:0] req_byte [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[BYTE_W*gi +: BYTE_W];
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic locked, locked_nx;
  logic cur_last, cur_last_nx;

  // While locked, only the previous owner may be considered.
  assign req_elig = locked ? (req_valid & (N_REQ'(1) << last_gnt)) : req_valid;
`else
  assign req_elig = req_valid;
`endif

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req_elig),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .found    (pick_found)
  );

  // A busy serializer seen in IDLE belongs to someone else: hold off.
  assign launch    = (state == IDLE) && !uart_tx_busy && pick_found;
  // Gated by resetn so ready is low for the whole time reset is asserted.
  assign req_ready = (launch && resetn) ? pick_gnt : '0;
  // Busy rising in the same cycle takes priority over the timeout.
  assign timeout   = (state == WAIT_BUSY) && !uart_tx_busy &&
                     (cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    en_nx    = uart_tx_en;
    data_nx  = uart_tx_data;
    gnt_nx   = arb_gnt;
    err_nx   = 1'b0;
    last_nx  = last_gnt;
    cur_nx   = cur_idx;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (launch) begin
          data_nx  = req_byte[pick_idx];
          en_nx    = 1'b1;
          gnt_nx   = pick_gnt;
          cur_nx   = pick_idx;
          cnt_nx   = '0;
          state_nx = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          en_nx    = 1'b0;
          state_nx = WAIT_DONE;
        end else if (timeout) begin
          // last_gnt is left alone so the same requester is retried first.
          en_nx    = 1'b0;
          gnt_nx   = '0;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          last_nx  = cur_idx;
          gnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_comb begin
    locked_nx   = locked;
    cur_last_nx = cur_last;
    if (launch) begin
      cur_last_nx = req_last[pick_idx];
    end
    if (timeout) begin
      locked_nx = 1'b0;
    end else if ((state == WAIT_DONE) && !uart_tx_busy) begin
      locked_nx = !cur_last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      locked   <= 1'b0;
      cur_last <= 1'b0;
    end else begin
      locked   <= locked_nx;
      cur_last <= cur_last_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      last_gnt     <= IDX_W'(N_REQ - 1);
      cur_idx      <= '0;
      cnt          <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      arb_gnt      <= '0;
      arb_err      <= 1'b0;
    end else begin
      state        <= state_nx;
      last_gnt     <= last_nx;
      cur_idx      <= cur_nx;
      cnt          <= cnt_nx;
      uart_tx_en   <= en_nx;
      uart_tx_data <= data_nx;
      arb_gnt      <= gnt_nx;
      arb_err      <= err_nx;
    end
  end

endmodule
